// File: rtl/memchk_pkg.sv
// memchk_pkg
// Shared types for the data-memory write checker:
//   memchk_state_t : checker FSM state (RUN, PASS, FAIL)
//   memchk_fail_t  : failure reason reported on fail_code_o
package memchk_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } memchk_state_t;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    MISMATCH  = 2'd1,
    DUPLICATE = 2'd2,
    TIMEOUT   = 2'd3
  } memchk_fail_t;

endpackage

// File: rtl/memchk_timeout.sv
// memchk_timeout
// Cycle counter that flags expiry when it has counted LIMIT-1 enabled
// cycles, i.e. on the LIMIT-th enabled cycle after clear.
// Ports:
//   clk_i     : clock, rising edge
//   clr_i     : synchronous clear (highest priority)
//   en_i      : count enable
//   expired_o : high in the enabled cycle where the count equals LIMIT-1
module memchk_timeout #(
  parameter int LIMIT = 1000
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] cnt;

  assign expired_o = en_i && (cnt == CW'(LIMIT - 1));

  // Holds at the limit once expired; the owner stops enabling after expiry.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt <= '0;
    end else if (en_i && !expired_o) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker
// Watches the core data-memory write port and matches writes against a
// table of NUM_EXP expected (address, data) pairs, either in table order
// (ORDERED=1) or in any order with each entry consumed once (ORDERED=0).
// Writes to scratch_adr_i are ignored. A cycle timeout (TIMEOUT_CYC, 0 =
// disabled) fails the run if it does not pass in time. Results are sticky
// until reset and appear one cycle after the deciding write.
// Optional build macro: MEMCHK_WRCNT_EN adds wr_cnt_o, a saturating count of
// every sampled write strobe.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   mem_write_i           : write strobe from core
//   data_adr_i            : write address
//   write_data_i          : write data
//   scratch_adr_i         : address whose writes are ignored
//   exp_adr_i, exp_data_i : packed expected table, entry 0 in LSBs
//   done_o, pass_o        : sticky finished / passed
//   fail_code_o           : memchk_fail_t reason
//   fail_adr_o/fail_data_o: offending write (0 on timeout)
//   match_cnt_o           : entries matched so far
//   wr_cnt_o              : (MEMCHK_WRCNT_EN only) sampled write count
module mem_write_checker
  import memchk_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_EXP     = 1,
  parameter int ORDERED     = 1,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         mem_write_i,
  input  logic [ADDR_W-1:0]            data_adr_i,
  input  logic [DATA_W-1:0]            write_data_i,
  input  logic [ADDR_W-1:0]            scratch_adr_i,
  input  logic [NUM_EXP*ADDR_W-1:0]    exp_adr_i,
  input  logic [NUM_EXP*DATA_W-1:0]    exp_data_i,
  output logic                         done_o,
  output logic                         pass_o,
  output logic [1:0]                   fail_code_o,
  output logic [ADDR_W-1:0]            fail_adr_o,
  output logic [DATA_W-1:0]            fail_data_o,
  output logic [$clog2(NUM_EXP+1)-1:0] match_cnt_o
`ifdef MEMCHK_WRCNT_EN
  ,
  output logic [31:0]                  wr_cnt_o
`endif
);

  localparam int CNT_W = $clog2(NUM_EXP + 1);

  memchk_state_t      state;
  memchk_fail_t       bad_code;
  logic [NUM_EXP-1:0] seen;
  logic [NUM_EXP-1:0] hit;
  logic [NUM_EXP-1:0] free_hit;
  logic [NUM_EXP-1:0] take;
  logic               wr_valid;
  logic               wr_good;
  logic               wr_last;
  logic               run_en;
  logic               tmo_expired;

  // Scratch writes are invisible to matching in every state.
  assign wr_valid = mem_write_i && (data_adr_i != scratch_adr_i);
  assign wr_last  = (match_cnt_o == CNT_W'(NUM_EXP - 1));
  assign run_en   = (state == RUN);

  // Full-width compare of the current write against every table entry.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_EXP; i++) begin
      hit[i] = (exp_adr_i[i*ADDR_W +: ADDR_W] == data_adr_i) &&
               (exp_data_i[i*DATA_W +: DATA_W] == write_data_i);
    end
  end

  // Lowest unseen matching entry; duplicate table rows are consumed one per write.
  assign free_hit = hit & ~seen;
  assign take     = free_hit & (~free_hit + NUM_EXP'(1));

  always_comb begin
    wr_good  = 1'b0;
    bad_code = MISMATCH;
    if (ORDERED != 0) begin
      // Only the entry at the current match index may be accepted.
      for (int i = 0; i < NUM_EXP; i++) begin
        if (match_cnt_o == CNT_W'(i)) wr_good = hit[i];
      end
    end else begin
      wr_good = |free_hit;
      if (|hit) bad_code = DUPLICATE;
    end
  end

  generate
    if (TIMEOUT_CYC > 0) begin : g_tmo
      memchk_timeout #(
        .LIMIT(TIMEOUT_CYC)
      ) u_tmo (
        .clk_i    (clk_i),
        .clr_i    (rst_i),
        .en_i     (run_en),
        .expired_o(tmo_expired)
      );
    end else begin : g_no_tmo
      assign tmo_expired = 1'b0;
    end
  endgenerate

  // Checker FSM. A deciding write beats the timeout on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= RUN;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_code_o <= NONE;
      fail_adr_o  <= '0;
      fail_data_o <= '0;
      match_cnt_o <= '0;
      seen        <= '0;
    end else if (state == RUN) begin
      if (wr_valid && wr_good) begin
        match_cnt_o <= match_cnt_o + CNT_W'(1);
        if (ORDERED == 0) seen <= seen | take;
      end
      if (wr_valid && !wr_good) begin
        state       <= FAIL;
        done_o      <= 1'b1;
        fail_code_o <= bad_code;
        fail_adr_o  <= data_adr_i;
        fail_data_o <= write_data_i;
      end else if (wr_valid && wr_last) begin
        state  <= PASS;
        done_o <= 1'b1;
        pass_o <= 1'b1;
      end else if (tmo_expired) begin
        state       <= FAIL;
        done_o      <= 1'b1;
        fail_code_o <= TIMEOUT;
      end
    end
  end

`ifdef MEMCHK_WRCNT_EN
  // Counts every strobe, scratch and post-done included; saturates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cnt_o <= '0;
    end else if (mem_write_i && (wr_cnt_o != '1)) begin
      wr_cnt_o <= wr_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker
// Three checker instances share one write bus:
//   d0: NUM_EXP=1, ordered,   timeout 50
//   d1: NUM_EXP=2, unordered, timeout 50
//   d2: NUM_EXP=3, ordered,   timeout disabled
// Each has its own table and scratch address. The driver applies a cycle,
// steps a behavioural model of each checker and queues the expected outputs;
// a negedge monitor pops and compares.
module tb_mem_write_checker;

  // ---------------- clock / reset / bus ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_write;
  logic [31:0] adr;
  logic [31:0] wdata;

  logic [31:0] t_adr[3][3];
  logic [31:0] t_dat[3][3];
  logic [31:0] scr[3];

  logic [31:0] ea0, ed0;
  logic [63:0] ea1, ed1;
  logic [95:0] ea2, ed2;
  assign ea0 = t_adr[0][0];
  assign ed0 = t_dat[0][0];
  assign ea1 = {t_adr[1][1], t_adr[1][0]};
  assign ed1 = {t_dat[1][1], t_dat[1][0]};
  assign ea2 = {t_adr[2][2], t_adr[2][1], t_adr[2][0]};
  assign ed2 = {t_dat[2][2], t_dat[2][1], t_dat[2][0]};

  logic        o_done[3];
  logic        o_pass[3];
  logic [1:0]  o_code[3];
  logic [31:0] o_fa[3];
  logic [31:0] o_fd[3];
  logic [0:0]  cnt0;
  logic [1:0]  cnt1, cnt2;
`ifdef MEMCHK_WRCNT_EN
  logic [31:0] wrc0, wrc1, wrc2;
`endif

  mem_write_checker #(.NUM_EXP(1), .ORDERED(1), .TIMEOUT_CYC(50)) u_d0 (
    .clk_i(clk), .rst_i(rst), .mem_write_i(mem_write), .data_adr_i(adr),
    .write_data_i(wdata), .scratch_adr_i(scr[0]), .exp_adr_i(ea0), .exp_data_i(ed0),
    .done_o(o_done[0]), .pass_o(o_pass[0]), .fail_code_o(o_code[0]),
    .fail_adr_o(o_fa[0]), .fail_data_o(o_fd[0]), .match_cnt_o(cnt0)
`ifdef MEMCHK_WRCNT_EN
    , .wr_cnt_o(wrc0)
`endif
  );

  mem_write_checker #(.NUM_EXP(2), .ORDERED(0), .TIMEOUT_CYC(50)) u_d1 (
    .clk_i(clk), .rst_i(rst), .mem_write_i(mem_write), .data_adr_i(adr),
    .write_data_i(wdata), .scratch_adr_i(scr[1]), .exp_adr_i(ea1), .exp_data_i(ed1),
    .done_o(o_done[1]), .pass_o(o_pass[1]), .fail_code_o(o_code[1]),
    .fail_adr_o(o_fa[1]), .fail_data_o(o_fd[1]), .match_cnt_o(cnt1)
`ifdef MEMCHK_WRCNT_EN
    , .wr_cnt_o(wrc1)
`endif
  );

  mem_write_checker #(.NUM_EXP(3), .ORDERED(1), .TIMEOUT_CYC(0)) u_d2 (
    .clk_i(clk), .rst_i(rst), .mem_write_i(mem_write), .data_adr_i(adr),
    .write_data_i(wdata), .scratch_adr_i(scr[2]), .exp_adr_i(ea2), .exp_data_i(ed2),
    .done_o(o_done[2]), .pass_o(o_pass[2]), .fail_code_o(o_code[2]),
    .fail_adr_o(o_fa[2]), .fail_data_o(o_fd[2]), .match_cnt_o(cnt2)
`ifdef MEMCHK_WRCNT_EN
    , .wr_cnt_o(wrc2)
`endif
  );

  // ---------------- reference model ----------------
  int cfg_n[3]   = '{1, 2, 3};
  int cfg_ord[3] = '{1, 0, 1};
  int cfg_to[3]  = '{50, 50, 0};

  // m_state: 0 running, 1 passed, 2 failed
  int          m_state[3];
  int          m_code[3];
  int          m_cnt[3];
  int          m_tcnt[3];
  logic [31:0] m_fadr[3];
  logic [31:0] m_fdat[3];
  bit          m_seen[3][3];

  task automatic model_step(int d, bit r, bit we, logic [31:0] a, logic [31:0] w);
    int  pick;
    bit  any;
    if (r) begin
      m_state[d] = 0; m_code[d] = 0; m_cnt[d] = 0; m_tcnt[d] = 0;
      m_fadr[d] = '0; m_fdat[d] = '0;
      for (int i = 0; i < 3; i++) m_seen[d][i] = 1'b0;
      return;
    end
    if (m_state[d] != 0) return;
    if (we && a != scr[d]) begin
      pick = -1;
      any  = 1'b0;
      if (cfg_ord[d] != 0) begin
        if (t_adr[d][m_cnt[d]] == a && t_dat[d][m_cnt[d]] == w) pick = m_cnt[d];
      end else begin
        for (int i = 0; i < cfg_n[d]; i++) begin
          if (t_adr[d][i] == a && t_dat[d][i] == w) begin
            any = 1'b1;
            if (!m_seen[d][i] && pick < 0) pick = i;
          end
        end
      end
      if (pick >= 0) begin
        m_seen[d][pick] = 1'b1;
        m_cnt[d] = m_cnt[d] + 1;
        if (m_cnt[d] == cfg_n[d]) begin
          m_state[d] = 1;
          return;
        end
      end else begin
        m_state[d] = 2;
        m_code[d]  = any ? 2 : 1;
        m_fadr[d]  = a;
        m_fdat[d]  = w;
        return;
      end
    end
    if (cfg_to[d] != 0 && m_tcnt[d] == cfg_to[d] - 1) begin
      m_state[d] = 2;
      m_code[d]  = 3;
    end else begin
      m_tcnt[d] = m_tcnt[d] + 1;
    end
  endtask

  // {done, pass, code[1:0], fail_adr[31:0], fail_data[31:0], cnt[1:0]}
  function automatic logic [69:0] model_vec(int d);
    logic       dn, ps;
    logic [1:0] cd, ct;
    dn = (m_state[d] != 0);
    ps = (m_state[d] == 1);
    cd = 2'(m_code[d]);
    ct = 2'(m_cnt[d]);
    return {dn, ps, cd, m_fadr[d], m_fdat[d], ct};
  endfunction

  function automatic logic [69:0] dut_vec(int d);
    logic [1:0] ct;
    case (d)
      0:       ct = {1'b0, cnt0};
      1:       ct = cnt1;
      default: ct = cnt2;
    endcase
    return {o_done[d], o_pass[d], o_code[d], o_fa[d], o_fd[d], ct};
  endfunction

  // ---------------- scoreboard ----------------
  logic [69:0] exp_q0[$];
  logic [69:0] exp_q1[$];
  logic [69:0] exp_q2[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc_no = 0;

  task automatic check(int d, logic [69:0] e);
    logic [69:0] g;
    g = dut_vec(d);
    n_vec++;
    if (g !== e) begin
      n_err++;
      $display("FAIL dut%0d cyc %0d: got done=%b pass=%b code=%0d adr=%0d data=%0d cnt=%0d; want done=%b pass=%b code=%0d adr=%0d data=%0d cnt=%0d",
               d, cyc_no, g[69], g[68], g[67:66], g[65:34], g[33:2], g[1:0],
               e[69], e[68], e[67:66], e[65:34], e[33:2], e[1:0]);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q0.size() > 0) check(0, exp_q0.pop_front());
    if (exp_q1.size() > 0) check(1, exp_q1.pop_front());
    if (exp_q2.size() > 0) check(2, exp_q2.pop_front());
  end

  // ---------------- driver ----------------
  task automatic cyc(bit r, bit we, logic [31:0] a, logic [31:0] w);
    rst       = r;
    mem_write = we;
    adr       = a;
    wdata     = w;
    @(posedge clk);
    cyc_no++;
    for (int d = 0; d < 3; d++) model_step(d, r, we, a, w);
    exp_q0.push_back(model_vec(0));
    exp_q1.push_back(model_vec(1));
    exp_q2.push_back(model_vec(2));
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic fixed_tables();
    for (int d = 0; d < 3; d++) begin
      scr[d] = 32'd96;
      for (int i = 0; i < 3; i++) begin
        t_adr[d][i] = 32'd0;
        t_dat[d][i] = 32'd0;
      end
    end
    t_adr[0][0] = 32'd100; t_dat[0][0] = 32'd7;
    t_adr[1][0] = 32'd8;   t_dat[1][0] = 32'd1;
    t_adr[1][1] = 32'd12;  t_dat[1][1] = 32'd2;
    t_adr[2][0] = 32'd8;   t_dat[2][0] = 32'd1;
    t_adr[2][1] = 32'd12;  t_dat[2][1] = 32'd2;
    t_adr[2][2] = 32'd16;  t_dat[2][2] = 32'd3;
  endtask

  task automatic random_tables();
    for (int d = 0; d < 3; d++) begin
      scr[d] = 32'(4 * $urandom_range(2, 6));
      for (int i = 0; i < 3; i++) begin
        t_adr[d][i] = 32'(4 * $urandom_range(2, 5));
        t_dat[d][i] = 32'($urandom_range(0, 2));
      end
    end
  endtask

  task automatic random_write();
    int d;
    int i;
    logic [31:0] a, w;
    if ($urandom_range(0, 2) == 0) begin
      idle(1);
    end else begin
      d = $urandom_range(0, 2);
      i = $urandom_range(0, cfg_n[d] - 1);
      a = t_adr[d][i];
      w = t_dat[d][i];
      if ($urandom_range(0, 5) == 0) a = scr[d];
      if ($urandom_range(0, 5) == 0) w = 32'($urandom_range(0, 3));
      cyc(1'b0, 1'b1, a, w);
    end
  endtask

  initial begin
    int drain;
    rst = 1'b1; mem_write = 1'b0; adr = '0; wdata = '0;
    fixed_tables();

    // Scratch write ignored, then the single expected write passes d0.
    do_reset(); do_reset();
    cyc(1'b0, 1'b1, 32'd96, 32'd5);
    cyc(1'b0, 1'b1, 32'd100, 32'd7);
    idle(2);

    // Wrong address fails with MISMATCH; a later correct write is ignored.
    do_reset();
    cyc(1'b0, 1'b1, 32'd104, 32'd7);
    cyc(1'b0, 1'b1, 32'd100, 32'd7);
    idle(2);

    // No writes: timeout on the 50th cycle after release.
    do_reset();
    idle(53);

    // Unordered duplicate, then unordered any-order pass.
    do_reset();
    cyc(1'b0, 1'b1, 32'd12, 32'd2);
    cyc(1'b0, 1'b1, 32'd12, 32'd2);
    idle(1);
    do_reset();
    cyc(1'b0, 1'b1, 32'd12, 32'd2);
    cyc(1'b0, 1'b1, 32'd8, 32'd1);
    idle(1);

    // Reset after one of two matches, then the full sequence.
    do_reset();
    cyc(1'b0, 1'b1, 32'd12, 32'd2);
    do_reset();
    idle(1);
    cyc(1'b0, 1'b1, 32'd12, 32'd2);
    cyc(1'b0, 1'b1, 32'd8, 32'd1);
    idle(1);

    // Final unordered match lands on the timeout edge (edge 50).
    do_reset();
    idle(48);
    cyc(1'b0, 1'b1, 32'd12, 32'd2);
    cyc(1'b0, 1'b1, 32'd8, 32'd1);
    idle(2);

    // Ordered 3-entry sequence on d2, then an out-of-order write.
    do_reset();
    cyc(1'b0, 1'b1, 32'd8, 32'd1);
    cyc(1'b0, 1'b1, 32'd16, 32'd3);
    idle(1);

    // Randomized episodes.
    for (int ep = 0; ep < 60; ep++) begin
      random_tables();
      do_reset();
      for (int k = 0; k < $urandom_range(8, 60); k++) random_write();
    end

    drain = 0;
    while ((exp_q0.size() + exp_q1.size() + exp_q2.size()) > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if ((exp_q0.size() + exp_q1.size() + exp_q2.size()) > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, want 0",
               exp_q0.size() + exp_q1.size() + exp_q2.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
